wb_write_queue: RTL



---
 rtl/wb_write_queue_if.sv | 70 +++++++
 rtl/wb_write_queue.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue_if.sv
//==============================================================================
// Module      : wb_write_queue_if
// Description : Bundles the writeback queue's producer handshakes, the
//               register-file write port and the decode hazard lookups.
//               slave  = queue side, master = producer/decode/regfile side.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface wb_write_queue_if #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Producer 0: ALU / execute
  logic          src0_valid;
  logic          src0_ready;
  logic [AW-1:0] src0_addr;
  logic [DW-1:0] src0_data;

  // Producer 1: load/store unit
  logic          src1_valid;
  logic          src1_ready;
  logic [AW-1:0] src1_addr;
  logic [DW-1:0] src1_data;

  // Register-file write port
  logic          w_en3;
  logic [AW-1:0] addr3;
  logic [DW-1:0] w_data3;

  // Decode hazard lookup
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic          busy1;
  logic          busy2;
  logic [DW-1:0] fwd1_data;
  logic [DW-1:0] fwd2_data;

  // Occupancy
  logic [CW-1:0] count;

  modport slave (
    input  src0_valid, src0_addr, src0_data,
    output src0_ready,
    input  src1_valid, src1_addr, src1_data,
    output src1_ready,
    output w_en3, addr3, w_data3,
    input  rs1_addr, rs2_addr,
    output busy1, busy2, fwd1_data, fwd2_data,
    output count
  );

  modport master (
    output src0_valid, src0_addr, src0_data,
    input  src0_ready,
    output src1_valid, src1_addr, src1_data,
    input  src1_ready,
    input  w_en3, addr3, w_data3,
    output rs1_addr, rs2_addr,
    input  busy1, busy2, fwd1_data, fwd2_data,
    input  count
  );

endinterface

`default_nettype wire

// File: rtl/wb_write_queue.sv
//==============================================================================
// Module      : wb_write_queue
// Description : Writeback queue in front of the register file's single write
//               port. Two producers (src0 = ALU, src1 = LSU) push into an
//               in-order circular buffer; one entry drains per cycle onto
//               w_en3/addr3/w_data3. Pending-write lookups for two decode read
//               addresses report RAW hazards against queued writes.
//               Optional feature macro: WB_QUEUE_FWD_EN (youngest-match data
//               forwarding on fwd1_data/fwd2_data; tied to 0 when undefined).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  wb_write_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] C_CNT_ALMOST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] C_CNT_ROOM2  = CW'(DEPTH - 2);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [AW-1:0] r_addr_mem [DEPTH];
  logic [DW-1:0] r_data_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic          w_src0_ready;
  logic          w_src1_ready;
  logic          w_push0;
  logic          w_push1;
  logic [1:0]    w_npush;
  logic          w_pop;
  logic [PW-1:0] w_wr_idx1;
  logic [PW-1:0] w_wr_ptr_next;
  logic [PW-1:0] w_rd_ptr_next;
  logic [CW-1:0] w_count_next;

  logic [DEPTH-1:0] w_occ;
  logic [DEPTH-1:0] w_hit1;
  logic [DEPTH-1:0] w_hit2;
  logic             w_rs1_nz;
  logic             w_rs2_nz;

  // Readiness looks only at the registered occupancy; a same-cycle pop earns
  // no credit. src1 may take the last slot only when src0 is not competing
  // for it, which keeps src0 ahead in program order. Both are held low while
  // reset is asserted.
  always_comb begin
    w_src0_ready = rst_n && (r_count <= C_CNT_ALMOST);
    w_src1_ready = rst_n &&
                   ((r_count <= C_CNT_ROOM2) ||
                    ((r_count == C_CNT_ALMOST) && !bus.src0_valid));
  end

  assign bus.src0_ready = w_src0_ready;
  assign bus.src1_ready = w_src1_ready;

  // A completed handshake to x0 is swallowed: it never occupies a slot.
  always_comb begin
    w_push0 = bus.src0_valid && w_src0_ready && (bus.src0_addr != '0);
    w_push1 = bus.src1_valid && w_src1_ready && (bus.src1_addr != '0);
    w_npush = {1'b0, w_push0} + {1'b0, w_push1};
    w_pop   = (r_count != '0);
  end

  // src1 lands right behind src0 when both push; otherwise it takes the
  // current tail slot so the buffer stays dense.
  always_comb begin
    w_wr_idx1     = w_push0 ? (r_wr_ptr + PW'(1)) : r_wr_ptr;
    w_wr_ptr_next = r_wr_ptr + PW'(w_npush);
    w_rd_ptr_next = r_rd_ptr + PW'(w_pop);
    w_count_next  = r_count + CW'(w_npush) - CW'(w_pop);
  end

  // Pointer and occupancy registers; reset discards every queued write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
    end
  end

  // Entry storage; stale contents are harmless because occupancy gates use.
  always_ff @(posedge clk) begin
    if (w_push0) begin
      r_addr_mem[r_wr_ptr] <= bus.src0_addr;
      r_data_mem[r_wr_ptr] <= bus.src0_data;
    end
    if (w_push1) begin
      r_addr_mem[w_wr_idx1] <= bus.src1_addr;
      r_data_mem[w_wr_idx1] <= bus.src1_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Drain: head entry is presented every non-empty cycle and pops on the edge
  // the register file commits it.
  // ---------------------------------------------------------------------------
  assign bus.w_en3   = w_pop;
  assign bus.addr3   = w_pop ? r_addr_mem[r_rd_ptr] : '0;
  assign bus.w_data3 = w_pop ? r_data_mem[r_rd_ptr] : '0;
  assign bus.count   = r_count;

  // ---------------------------------------------------------------------------
  // Hazard lookup. An entry is occupied when its distance from the head,
  // modulo DEPTH, is below the occupancy count. x0 never matches because it
  // is never stored and reads of x0 are never hazards.
  // ---------------------------------------------------------------------------
  assign w_rs1_nz = (bus.rs1_addr != '0);
  assign w_rs2_nz = (bus.rs2_addr != '0);

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PW-1:0] w_offset;
    assign w_offset  = PW'(i) - r_rd_ptr;
    assign w_occ[i]  = ({1'b0, w_offset} < r_count);
    assign w_hit1[i] = w_occ[i] && w_rs1_nz && (r_addr_mem[i] == bus.rs1_addr);
    assign w_hit2[i] = w_occ[i] && w_rs2_nz && (r_addr_mem[i] == bus.rs2_addr);
  end

  assign bus.busy1 = |w_hit1;
  assign bus.busy2 = |w_hit2;

`ifdef WB_QUEUE_FWD_EN
  logic [DW-1:0] w_fwd1;
  logic [DW-1:0] w_fwd2;

  // Walk from head to tail; a later (younger) match overwrites an older one,
  // so the value left is the one the register file will hold last.
  always_comb begin
    logic [PW-1:0] v_idx;
    w_fwd1 = '0;
    w_fwd2 = '0;
    v_idx  = r_rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      v_idx = r_rd_ptr + PW'(k);
      if (w_hit1[v_idx]) begin
        w_fwd1 = r_data_mem[v_idx];
      end
      if (w_hit2[v_idx]) begin
        w_fwd2 = r_data_mem[v_idx];
      end
    end
  end

  assign bus.fwd1_data = w_fwd1;
  assign bus.fwd2_data = w_fwd2;
`else
  assign bus.fwd1_data = '0;
  assign bus.fwd2_data = '0;
`endif

endmodule

`default_nettype wire
